// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store responder. Turns one load or store from the
// decoder into a single word-aligned req/gnt + rvalid data-bus transaction.
// The pipeline is held until that transaction completes. Load data is
// returned lane-selected and sign- or zero-extended.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses skip the bus and pulse misalign_o.
//   undefined : the low address bits are ignored per access size, and the
//               access is performed normally (misalign_o is held at 0).
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   ctrl_mem_re_i/we_i      load / store request (a store wins if both are set)
//   funct3_i                RV32I size/sign (B, H, W, BU, HU)
//   addr_i, wdata_i         byte address, store data
//   lsu_stall_o             hold the pipeline
//   rdata_o, rdata_valid_o  extended load data, one-cycle completion pulse
//   misalign_o              one-cycle misaligned-access pulse
//   bus_*                   data-bus request/response channel
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no access in flight; accepts re/we
// REQ   | bus_req_o high, waiting for bus_gnt_i
// WAIT  | granted, waiting for bus_rvalid_i
// DONE  | completion pulse; the pipeline advances
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ctrl_mem_re_i,
  input  logic        ctrl_mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;

  logic [1:0]  req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request formatting. funct3[1:0]==11 is treated as a word access.
  always_comb begin
    req_size  = SZ_W;
    req_be    = 4'b1111;
    req_wdata = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        req_size  = SZ_B;
        req_be    = 4'b0001 << addr_i[1:0];
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        req_size  = SZ_H;
        req_be    = 4'b0011 << {addr_i[1], 1'b0};
        req_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        req_size  = SZ_W;
        req_be    = 4'b1111;
        req_wdata = wdata_i;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic req_misalign;
  assign req_misalign = ((req_size == SZ_H) && addr_i[0]) ||
                        ((req_size == SZ_W) && (addr_i[1:0] != 2'b00));
`endif

  // Load formatting from the latched size/sign/offset of the access.
  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    case (off_q)
      2'd0:    ld_byte = bus_rdata_i[7:0];
      2'd1:    ld_byte = bus_rdata_i[15:8];
      2'd2:    ld_byte = bus_rdata_i[23:16];
      default: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (size_q)
      SZ_B:    ld_data = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata_i;
    endcase
  end

  // The stall must rise in the same cycle the request appears, so the
  // IDLE term is combinational.
  assign lsu_stall_o = ((state == S_IDLE) && (ctrl_mem_re_i || ctrl_mem_we_i)) ||
                       (state == S_REQ) || (state == S_WAIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      size_q        <= SZ_B;
      unsigned_q    <= 1'b0;
      off_q         <= 2'b00;
      rdata_o       <= 32'h0;
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 32'h0;
      bus_be_o      <= 4'h0;
      bus_wdata_o   <= 32'h0;
    end else begin
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl_mem_re_i || ctrl_mem_we_i) begin
            bus_we_o    <= ctrl_mem_we_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= req_be;
            bus_wdata_o <= req_wdata;
            size_q      <= req_size;
            unsigned_q  <= funct3_i[2];
            off_q       <= addr_i[1:0];
`ifdef MISALIGN_TRAP_EN
            if (req_misalign) begin
              state         <= S_DONE;
              rdata_valid_o <= 1'b1;
              misalign_o    <= 1'b1;
              rdata_o       <= 32'h0;
            end else begin
              state     <= S_REQ;
              bus_req_o <= 1'b1;
            end
`else
            state     <= S_REQ;
            bus_req_o <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          // rvalid is deliberately ignored here; only gnt moves us on.
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            state         <= S_DONE;
            rdata_valid_o <= 1'b1;
            if (!bus_we_o) rdata_o <= ld_data;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ctrl_mem_re_i, ctrl_mem_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        lsu_stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, misalign_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int checks = 0;
  int failures = 0;

  // results of the last run_access
  int          r_stall;
  bit          r_req_seen, r_done;
  logic        r_we, r_mis;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_rdata;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ctrl_mem_re_i(ctrl_mem_re_i), .ctrl_mem_we_i(ctrl_mem_we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .lsu_stall_o(lsu_stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access and plays the bus: gnt after gdly REQ cycles,
  // rvalid after rdly WAIT cycles. Inputs change and outputs are sampled
  // just after the falling edge.
  task automatic run_access(input logic re, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int gdly, input int rdly);
    int  req_cyc = 0;
    int  wait_cyc = 0;
    bit  granted = 0;
    r_stall = 0; r_req_seen = 0; r_done = 0;
    r_we = 0; r_mis = 0; r_be = 0; r_addr = 0; r_wdata = 0; r_rdata = 0;
    @(negedge clk_i);
    ctrl_mem_re_i = re; ctrl_mem_we_i = we; funct3_i = f3;
    addr_i = a; wdata_i = wd; bus_rdata_i = word;
    for (int cyc = 0; cyc < 60 && !r_done; cyc++) begin
      #1;
      if (lsu_stall_o) r_stall++;
      bus_gnt_i = 1'b0;
      bus_rvalid_i = 1'b0;
      if (rdata_valid_o) begin
        r_done = 1; r_rdata = rdata_o; r_mis = misalign_o;
        ctrl_mem_re_i = 1'b0; ctrl_mem_we_i = 1'b0;
      end else if (bus_req_o) begin
        if (!r_req_seen) begin
          r_we = bus_we_o; r_be = bus_be_o; r_addr = bus_addr_o; r_wdata = bus_wdata_o;
        end
        r_req_seen = 1;
        if (req_cyc == gdly) begin
          bus_gnt_i = 1'b1;
          granted = 1;
        end
        req_cyc++;
      end else if (granted) begin
        if (wait_cyc == rdly) bus_rvalid_i = 1'b1;
        wait_cyc++;
      end
      @(negedge clk_i);
    end
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    ctrl_mem_re_i = 1'b0; ctrl_mem_we_i = 1'b0;
    check("completed", {31'b0, r_done}, 32'd1);
    #1;
    check("valid_one_cycle", {31'b0, rdata_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    ctrl_mem_re_i = 0; ctrl_mem_we_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req", {31'b0, bus_req_o}, 32'd0);
    check("rst_stall", {31'b0, lsu_stall_o}, 32'd0);
    check("rst_valid", {31'b0, rdata_valid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_be", {28'b0, bus_be_o}, 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_mis", {31'b0, misalign_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // LB at 0x1003
    run_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
    check("lb_be", {28'b0, r_be}, 32'h8);
    check("lb_addr", r_addr, 32'h0000_1000);
    check("lb_we", {31'b0, r_we}, 32'd0);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);
    check("lb_stall", r_stall, 32'd3);

    // LBU same access
    run_access(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
    check("lbu_rdata", r_rdata, 32'h0000_0080);

    // LB at byte 1
    run_access(1, 0, 3'b000, 32'h0000_1001, 32'h0, 32'h80FF_1234, 1, 0);
    check("lb1_be", {28'b0, r_be}, 32'h2);
    check("lb1_rdata", r_rdata, 32'h0000_0012);
    check("lb1_stall", r_stall, 32'd4);

    // SH at 0x2002; rdata_o keeps previous value
    run_access(0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0);
    check("sh_be", {28'b0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    check("sh_we", {31'b0, r_we}, 32'd1);
    check("sh_valid", {31'b0, r_done}, 32'd1);
    check("sh_rdata_keep", r_rdata, 32'h0000_0012);

    // LHU at 0x2002
    run_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8765_4321, 0, 0);
    check("lhu_rdata", r_rdata, 32'h0000_8765);

    // LW with gnt delayed 3 and rvalid delayed 2
    run_access(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h1234_5678, 3, 2);
    check("lw_stall", r_stall, 32'd8);
    check("lw_rdata", r_rdata, 32'h1234_5678);
    check("lw_be", {28'b0, r_be}, 32'hF);

    // re and we both high: store wins
    run_access(1, 1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h9999_9999, 0, 0);
    check("rw_we", {31'b0, r_we}, 32'd1);
    check("rw_be", {28'b0, r_be}, 32'hF);
    check("rw_addr", r_addr, 32'h0000_0010);
    check("rw_wdata", r_wdata, 32'hCAFE_F00D);
    check("rw_rdata_keep", r_rdata, 32'h1234_5678);

    // LH at 0x3001
    run_access(1, 0, 3'b001, 32'h0000_3001, 32'h0, 32'hABCD_8765, 0, 0);
`ifdef MISALIGN_TRAP_EN
    check("lh_mis_req", {31'b0, r_req_seen}, 32'd0);
    check("lh_mis_flag", {31'b0, r_mis}, 32'd1);
    check("lh_mis_stall", r_stall, 32'd1);
    check("lh_mis_rdata", r_rdata, 32'h0);
`else
    check("lh_req", {31'b0, r_req_seen}, 32'd1);
    check("lh_be", {28'b0, r_be}, 32'h3);
    check("lh_mis_flag", {31'b0, r_mis}, 32'd0);
    check("lh_rdata", r_rdata, 32'hFFFF_8765);
`endif

    // Reset during WAIT, then a stray rvalid
    @(negedge clk_i);
    ctrl_mem_re_i = 1; funct3_i = 3'b010; addr_i = 32'h0000_5000; bus_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    #1;
    check("rw2_req", {31'b0, bus_req_o}, 32'd1);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    #1;
    check("rw2_wait_stall", {31'b0, lsu_stall_o}, 32'd1);
    rst_n_i = 1'b0;
    ctrl_mem_re_i = 0;
    #1;
    check("rstw_stall", {31'b0, lsu_stall_o}, 32'd0);
    check("rstw_be", {28'b0, bus_be_o}, 32'h0);
    check("rstw_addr", bus_addr_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bus_rvalid_i = 1'b1;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    #1;
    check("stray_valid", {31'b0, rdata_valid_o}, 32'd0);
    check("stray_rdata", rdata_o, 32'h0);
    check("stray_stall", {31'b0, lsu_stall_o}, 32'd0);

    run_access(1, 0, 3'b010, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 0, 0);
    check("post_rst_rdata", r_rdata, 32'h0BAD_F00D);
    check("post_rst_stall", r_stall, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage responder for the per-instruction load/store controls (`mem_re`, `mem_we`) produced by the core's decoder. It turns one load or store into a single word-aligned transaction on the data-bus. The transaction uses a req/gnt request phase and an rvalid response phase. The unit stalls the pipeline until that transaction completes and returns load data already lane-selected and sign- or zero-extended for writeback.

## Interface
Parameters:
- none (32-bit address/data fixed)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- ctrl_mem_re_i  in  1  load request from decode/execute
- ctrl_mem_we_i  in  1  store request; wins if both high (re ignored)
- funct3_i  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; `funct3_i[1:0]==11` treated as W
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- lsu_stall_o  out  1  hold pipeline; inputs must stay stable while high
- rdata_o  out  32  extended load data, valid with rdata_valid_o
- rdata_valid_o  out  1  one-cycle completion pulse (loads and stores)
- misalign_o  out  1  one-cycle misaligned-access pulse (see Configuration)
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  `{addr_i[31:2], 2'b00}`
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  response/ack; for stores, data ignored
- bus_rdata_i  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `re|we`, latch addr, funct3, we and formatted wdata/be, then go to REQ (or DONE if misaligned and trap enabled).
  - Otherwise stay in IDLE.
- REQ:
  - bus_req_o=1; bus_* outputs come from registers and are stable.
  - On `bus_gnt_i`, go to WAIT.
- WAIT:
  - On `bus_rvalid_i`, capture and format rdata, then go to DONE.
- DONE:
  - rdata_valid_o=1 and stall low; the pipeline advances at this edge.
  - Return to IDLE unconditionally. No new request is accepted in DONE.
- lsu_stall_o = `(IDLE & (re|we)) | REQ | WAIT`; it is combinational in IDLE.
- Byte enables:
  - B: `0001 << addr[1:0]`
  - H: `0011 << {addr[1],1'b0}`
  - W: `1111`
- Store data: B `{4{wdata[7:0]}}`, H `{2{wdata[15:0]}}`, W unchanged.
- Load data:
  - Select byte `addr[1:0]` or halfword `addr[1]`.
  - `funct3[2]=0` sign-extends, `funct3[2]=1` zero-extends.
- Store completion leaves rdata_o unchanged from its previous value.
- Misaligned means H with `addr[0]=1`, or W with `addr[1:0]!=0`.

## Timing
- Reset values: all outputs 0; state IDLE. Assertion takes effect immediately and drops bus_req_o mid-REQ.
- A bus_rvalid_i arriving after a reset, or while in IDLE, REQ or DONE, is ignored.
- Minimum latency (gnt in first REQ cycle, rvalid next cycle): stall high for 3 cycles, rdata_valid_o in the 4th.
- gnt and rvalid in the same cycle is illegal for the bus. Any rvalid seen in REQ is ignored.
- A gnt stall of N cycles extends stall by N. An rvalid stall of M cycles extends it by M.
- bus_req_o never deasserts before gnt, except on reset.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned access issues no bus transaction; the FSM goes IDLE→DONE.
  - In DONE, misalign_o=1, rdata_valid_o=1 and rdata_o=0; stall is high for 1 cycle.
- Not defined:
  - misalign_o is tied 0.
  - Low address bits are ignored per size: H uses `{addr[1],0}`, W uses `00`.
  - The access is performed normally.

## Test plan
- LB: addr 0x1003, bus word 0x80FF_1234 → bus_be_o=1000, rdata_o=0xFFFF_FF80. The same access with LBU → 0x0000_0080.
- SH: addr 0x2002, wdata 0xDEAD_BEEF → bus_be_o=1100, bus_wdata_o=0xBEEF_BEEF, bus_we_o=1. rdata_valid_o pulses after ack.
- LW with gnt delayed 3 cycles and rvalid delayed 2 → stall high exactly 8 cycles; rdata_o equals bus word.
- re and we both high, SW addr 0x10 → write transaction only, bus_be_o=1111.
- LH at 0x3001: with `MISALIGN_TRAP_EN`, no bus_req_o and misalign_o pulse after 1 stall cycle. Without it, bus_be_o=0011 and a normal load.
- rst_n_i low during WAIT, then rvalid arrives → outputs 0 immediately, rvalid ignored, next LW completes normally.
